// File: rtl/pe_array.sv
// pe_array: ROWS x COLS output-stationary systolic multiply-accumulate tile.
//
// Skewed A rows enter from the left and skewed B columns from the top while
// en is high; every PE accumulates signed a*b into an OW-bit accumulator
// (wrapping). When en falls the accumulators drain through the bottom row,
// one row per cycle (row ROWS-1 first), with valid high for ROWS cycles.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   en           compute enable; its falling edge starts the drain
//   valid        high while C_out carries a drained row
//   data_flow    dataflow select, output-stationary only; ignored
//   load         synchronous clear of accumulators/operand pipes, aborts drain
//   acc_en       add C_acc to drained rows (PE_ARRAY_ACC_EN builds only)
//   A            ROWS lanes of DATA_WIDTH, left input of each row
//   B            COLS lanes of DATA_WIDTH, top input of each column
//   C_out        COLS lanes of OW, bottom-row accumulators
//   C_acc        COLS lanes of OW partial sums (PE_ARRAY_ACC_EN builds only)
//
// Optional feature macro: PE_ARRAY_ACC_EN.

module pe_array #(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  output logic                           valid,
  input  logic                           data_flow,
  input  logic                           load,
  input  logic                           acc_en,
  input  logic [ROWS*DATA_WIDTH-1:0]     A,
  input  logic [COLS*DATA_WIDTH-1:0]     B,
  output logic [COLS*2*DATA_WIDTH-1:0]   C_out,
  input  logic [COLS*2*DATA_WIDTH-1:0]   C_acc
);

  localparam int OW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(ROWS + 1);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                        state;
  logic                          en_d1;
  logic [CW-1:0]                 counter;

  logic signed [DATA_WIDTH-1:0]  a_reg [ROWS][COLS];
  logic signed [DATA_WIDTH-1:0]  b_reg [ROWS][COLS];
  logic signed [DATA_WIDTH-1:0]  a_in  [ROWS][COLS];
  logic signed [DATA_WIDTH-1:0]  b_in  [ROWS][COLS];
  logic        [OW-1:0]          prod  [ROWS][COLS];
  logic        [OW-1:0]          acc   [ROWS][COLS];

  // Operand routing: edge PEs take the external lanes, inner PEs take the
  // registered operand of their left / upper neighbour.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      if (c == 0) begin : g_a_edge
        assign a_in[r][c] = A[r*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_a_inner
        assign a_in[r][c] = a_reg[r][c-1];
      end
      if (r == 0) begin : g_b_edge
        assign b_in[r][c] = B[c*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_b_inner
        assign b_in[r][c] = b_reg[r-1][c];
      end
      // Size casts of signed operands sign-extend, so the product wraps at OW.
      assign prod[r][c] = OW'(a_in[r][c]) * OW'(b_in[r][c]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      valid   <= 1'b0;
      en_d1   <= 1'b0;
      counter <= '0;
      for (int unsigned r = 0; r < ROWS; r++) begin
        for (int unsigned c = 0; c < COLS; c++) begin
          acc[r][c]   <= '0;
          a_reg[r][c] <= '0;
          b_reg[r][c] <= '0;
        end
      end
    end else begin
      en_d1 <= en;
      if (load) begin
        state   <= IDLE;
        valid   <= 1'b0;
        counter <= '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
          for (int unsigned c = 0; c < COLS; c++) begin
            acc[r][c]   <= '0;
            a_reg[r][c] <= '0;
            b_reg[r][c] <= '0;
          end
        end
      end else if (state == DRAIN) begin
        // Shift every row down one place; the bottom row is on C_out.
        for (int unsigned c = 0; c < COLS; c++) begin
          for (int unsigned r = 1; r < ROWS; r++) begin
            acc[r][c] <= acc[r-1][c];
          end
          acc[0][c] <= '0;
        end
        counter <= counter - 1'b1;
        if (counter == CW'(1)) begin
          state <= IDLE;
          valid <= 1'b0;
        end
      end else if (!en && en_d1) begin
        state   <= DRAIN;
        valid   <= 1'b1;
        counter <= CW'(ROWS);
        for (int unsigned r = 0; r < ROWS; r++) begin
          for (int unsigned c = 0; c < COLS; c++) begin
            a_reg[r][c] <= '0;
            b_reg[r][c] <= '0;
          end
        end
      end else if (en) begin
        for (int unsigned r = 0; r < ROWS; r++) begin
          for (int unsigned c = 0; c < COLS; c++) begin
            acc[r][c]   <= acc[r][c] + prod[r][c];
            a_reg[r][c] <= a_in[r][c];
            b_reg[r][c] <= b_in[r][c];
          end
        end
      end
    end
  end

  // C_out is combinational from the bottom row.
  for (genvar c = 0; c < COLS; c++) begin : g_out
`ifdef PE_ARRAY_ACC_EN
    assign C_out[c*OW +: OW] = (acc_en && valid) ? acc[ROWS-1][c] + C_acc[c*OW +: OW]
                                                 : acc[ROWS-1][c];
`else
    assign C_out[c*OW +: OW] = acc[ROWS-1][c];
`endif
  end

  // Inputs that carry no function in this build.
  logic unused_inputs;
`ifdef PE_ARRAY_ACC_EN
  assign unused_inputs = data_flow;
`else
  assign unused_inputs = ^{data_flow, acc_en, C_acc};
`endif

endmodule

// File: tb/tb_pe_array.sv
// tb_pe_array: randomized self-checking bench for pe_array. A matrix-level
// reference model (C += A*B mod 2^OW) predicts each drained row.

module tb_pe_array;

  localparam int R    = 4;
  localparam int C    = 3;
  localparam int DW   = 8;
  localparam int OW   = 2 * DW;
  localparam int KMAX = 8;

`ifdef PE_ARRAY_ACC_EN
  localparam bit HAS_ACC = 1'b1;
`else
  localparam bit HAS_ACC = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic              valid;
  logic              data_flow;
  logic              load;
  logic              acc_en;
  logic [R*DW-1:0]   A;
  logic [C*DW-1:0]   B;
  logic [C*OW-1:0]   C_out;
  logic [C*OW-1:0]   C_acc;

  int checks   = 0;
  int failures = 0;

  int              ma [R][KMAX];
  int              mb [KMAX][C];
  logic [OW-1:0]   acc_m  [R][C];
  logic [OW-1:0]   cacc_m [C];
  logic [C*OW-1:0] got_rows [R];

  pe_array #(.ROWS(R), .COLS(C), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .valid     (valid),
    .data_flow (data_flow),
    .load      (load),
    .acc_en    (acc_en),
    .A         (A),
    .B         (B),
    .C_out     (C_out),
    .C_acc     (C_acc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        acc_m[r][c] = '0;
  endtask

  task automatic clear_mats();
    for (int k = 0; k < KMAX; k++) begin
      for (int r = 0; r < R; r++) ma[r][k] = 0;
      for (int c = 0; c < C; c++) mb[k][c] = 0;
    end
  endtask

  task automatic rand_mats();
    for (int k = 0; k < KMAX; k++) begin
      for (int r = 0; r < R; r++) ma[r][k] = int'($urandom_range(0, 255)) - 128;
      for (int c = 0; c < C; c++) mb[k][c] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  task automatic set_cacc(input bit rnd, input logic [OW-1:0] v);
    for (int c = 0; c < C; c++) begin
      cacc_m[c] = rnd ? OW'($urandom) : v;
      C_acc[c*OW +: OW] = cacc_m[c];
    end
  endtask

  function automatic logic [C*OW-1:0] model_row(input int r, input bit add);
    logic [C*OW-1:0] res;
    logic [OW-1:0]   v;
    for (int c = 0; c < C; c++) begin
      v = acc_m[r][c];
      if (add) v = v + cacc_m[c];
      res[c*OW +: OW] = v;
    end
    return res;
  endfunction

  // Streams one K-chunk with skew and zero padding, en held high throughout.
  task automatic run_chunk(input int k);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        for (int kk = 0; kk < k; kk++)
          acc_m[r][c] = acc_m[r][c] + OW'(ma[r][kk] * mb[kk][c]);
    for (int t = 0; t < k + R + C - 2; t++) begin
      for (int r = 0; r < R; r++)
        A[r*DW +: DW] = (t - r >= 0 && t - r < k) ? DW'(ma[r][t-r]) : '0;
      for (int c = 0; c < C; c++)
        B[c*DW +: DW] = (t - c >= 0 && t - c < k) ? DW'(mb[t-c][c]) : '0;
      en = 1'b1;
      step();
    end
  endtask

  // Drops en and checks the ROWS drained rows and the idle state afterwards.
  task automatic drain(input string tag, input bit use_acc, input bit toggle);
    acc_en = use_acc;
    en = 1'b0;
    A = '0;
    B = '0;
    step();
    for (int i = 0; i < R; i++) begin
      check({tag, "_valid"}, 64'(valid), 64'd1);
      check({tag, "_row"}, 64'(C_out), 64'(model_row(R - 1 - i, use_acc && HAS_ACC)));
      got_rows[R-1-i] = C_out;
      if (toggle) begin
        en = (i % 2 == 0) && (i != R - 1);
        A = R*DW'($urandom);
        B = C*DW'($urandom);
      end
      step();
    end
    check({tag, "_end_valid"}, 64'(valid), 64'd0);
    check({tag, "_end_cout"}, 64'(C_out), 64'd0);
    clear_model();
    en = 1'b0;
    acc_en = 1'b0;
    A = '0;
    B = '0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; data_flow = 1'b0; load = 1'b0; acc_en = 1'b0;
    A = '0; B = '0; C_acc = '0;
    clear_model();
    set_cacc(1'b0, '0);
    step();
    step();
    check("reset_valid", 64'(valid), 64'd0);
    check("reset_cout", 64'(C_out), 64'd0);
    rst_n = 1'b1;
    step();
    check("idle_valid", 64'(valid), 64'd0);

    // 2x2 product embedded in the corner of the array.
    clear_mats();
    ma[0][0] = 1; ma[0][1] = 2; ma[1][0] = 3; ma[1][1] = 4;
    mb[0][0] = 5; mb[0][1] = 6; mb[1][0] = 7; mb[1][1] = 8;
    run_chunk(2);
    drain("mm2x2", 1'b0, 1'b0);
    check("mm2x2_row1", 64'(got_rows[1]), {16'd0, 16'd50, 16'd43});
    check("mm2x2_row0", 64'(got_rows[0]), {16'd0, 16'd22, 16'd19});

    // Same product with C_acc added during drain when the feature is built.
    set_cacc(1'b0, 16'd100);
    run_chunk(2);
    drain("accen", 1'b1, 1'b0);
    check("accen_row1", 64'(got_rows[1]),
          HAS_ACC ? {16'd100, 16'd150, 16'd143} : {16'd0, 16'd50, 16'd43});

    // Signed operands.
    clear_mats();
    ma[0][0] = -3; mb[0][0] = -4;
    run_chunk(1);
    drain("sgn_a", 1'b0, 1'b0);
    check("sgn_a_lane0", 64'(got_rows[0][OW-1:0]), 64'd12);
    ma[0][0] = -128; mb[0][0] = 127;
    run_chunk(1);
    drain("sgn_b", 1'b0, 1'b0);
    check("sgn_b_lane0", 64'(got_rows[0][OW-1:0]), 64'hC080);

    // Wrap-around across three 127*127 steps in every PE.
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < R; r++) ma[r][k] = 127;
      for (int c = 0; c < C; c++) mb[k][c] = 127;
    end
    run_chunk(3);
    drain("ovf", 1'b0, 1'b0);
    check("ovf_lane", 64'(got_rows[2][OW +: OW]), 64'hBD03);

    // Two chunks back to back with en held high accumulate.
    rand_mats();
    run_chunk(2);
    rand_mats();
    run_chunk(2);
    drain("chunks", 1'b0, 1'b0);

    // Reset on the second valid cycle.
    rand_mats();
    run_chunk(3);
    en = 1'b0;
    step();
    check("rstmid_v0", 64'(valid), 64'd1);
    check("rstmid_row", 64'(C_out), 64'(model_row(R - 1, 1'b0)));
    step();
    rst_n = 1'b0;
    #1;
    check("rstmid_valid", 64'(valid), 64'd0);
    check("rstmid_cout", 64'(C_out), 64'd0);
    step();
    rst_n = 1'b1;
    clear_model();
    step();
    step();
    check("rstmid_idle_valid", 64'(valid), 64'd0);
    check("rstmid_idle_cout", 64'(C_out), 64'd0);

    // load while computing discards everything streamed so far.
    rand_mats();
    run_chunk(4);
    load = 1'b1;
    en = 1'b1;
    A = R*DW'($urandom);
    B = C*DW'($urandom);
    step();
    load = 1'b0;
    A = '0;
    B = '0;
    clear_model();
    check("load_cout", 64'(C_out), 64'd0);
    check("load_valid", 64'(valid), 64'd0);
    rand_mats();
    run_chunk(3);
    drain("postload", 1'b0, 1'b1);

    // load during drain aborts it.
    rand_mats();
    run_chunk(2);
    en = 1'b0;
    step();
    check("loaddrain_v0", 64'(valid), 64'd1);
    load = 1'b1;
    step();
    load = 1'b0;
    clear_model();
    check("loaddrain_valid", 64'(valid), 64'd0);
    check("loaddrain_cout", 64'(C_out), 64'd0);
    step();
    check("loaddrain_idle", 64'(valid), 64'd0);

    // Randomized tiles.
    for (int it = 0; it < 8; it++) begin
      int nch;
      bit ua, tg;
      nch = int'($urandom_range(1, 2));
      ua = 1'($urandom);
      tg = 1'($urandom);
      data_flow = 1'($urandom);
      set_cacc(1'b1, '0);
      for (int n = 0; n < nch; n++) begin
        rand_mats();
        run_chunk(int'($urandom_range(1, KMAX)));
      end
      drain("rand", ua, tg);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
